// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_pkg
// Purpose  : Shared constants and types for the two-read, one-write register
//            file and its clear sequencer.
//            REG_WIDTH - default data width of each register
//            REG_DEPTH - default number of registers
//            rf_state_t - clear sequencer state (CLEAR, READY)
// Revision : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int REG_WIDTH = 32;
    localparam int REG_DEPTH = 32;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } rf_state_t;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/reg_file_clear_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : reg_file_clear_ctrl
// Purpose  : Post-reset clear sequencer. Walks entries 1..DEPTH-1 issuing a
//            zero-write strobe each cycle, then parks in READY.
// Ports    : i_clk      - clock, rising edge
//            i_rst      - synchronous active-high reset (restarts at entry 1)
//            o_busy     - high while the clear sequence runs
//            o_clr_we   - clear-write strobe for entry o_clr_addr
//            o_clr_addr - entry being cleared this cycle
// Revision : 1.0 - initial release
// ============================================================================
module reg_file_clear_ctrl
    import reg_file_pkg::*;
#(
    parameter  int DEPTH  = REG_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              i_clk,
    input  logic              i_rst,
    output logic              o_busy,
    output logic              o_clr_we,
    output logic [ADDR_W-1:0] o_clr_addr
);

    localparam logic [ADDR_W-1:0] c_cnt_first = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] c_cnt_last  = ADDR_W'(DEPTH - 1);

    rf_state_t         r_state;
    rf_state_t         w_state_nxt;
    logic [ADDR_W-1:0] r_cnt;
    logic [ADDR_W-1:0] w_cnt_nxt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= CLEAR;
            r_cnt   <= c_cnt_first;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // The counter saturates at the last entry: the edge that clears it
    // hands over to READY instead of incrementing.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        o_clr_we    = 1'b0;
        case (r_state)
            CLEAR: begin
                // A reset edge must leave storage untouched.
                o_clr_we = ~i_rst;
                if (r_cnt == c_cnt_last) begin
                    w_state_nxt = READY;
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            READY: begin
                w_state_nxt = READY;
            end
            default: begin
                w_state_nxt = CLEAR;
            end
        endcase
    end

    assign o_busy     = (r_state == CLEAR);
    assign o_clr_addr = r_cnt;

endmodule : reg_file_clear_ctrl
`default_nettype wire

// File: rtl/reg_file.sv
`default_nettype none
// ============================================================================
// Module   : reg_file
// Purpose  : Two-read, one-write register file fed by the write-back mux.
//            Entry 0 reads as zero and has no storage. After reset an internal
//            sequencer zeroes entries 1..DEPTH-1 before user writes are taken.
// Ports    : CLK        - clock, rising edge
//            RST        - synchronous active-high reset
//            EN, WA, WD - write enable / address / data
//            ADR1, ADR2 - combinational read addresses
//            RS1, RS2   - read data (forced to 0 while BUSY)
//            BUSY       - high while the clear sequence runs
// Config   : REG_FILE_BYPASS_EN - when defined, a read of WA during an
//            accepted write returns WD in the same cycle.
// Revision : 1.0 - initial release
// ============================================================================
module reg_file
    import reg_file_pkg::*;
#(
    parameter  int WIDTH  = REG_WIDTH,
    parameter  int DEPTH  = REG_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              EN,
    input  logic [ADDR_W-1:0] WA,
    input  logic [WIDTH-1:0]  WD,
    input  logic [ADDR_W-1:0] ADR1,
    input  logic [ADDR_W-1:0] ADR2,
    output logic [WIDTH-1:0]  RS1,
    output logic [WIDTH-1:0]  RS2,
    output logic              BUSY
);

    logic              w_busy;
    logic              w_clr_we;
    logic [ADDR_W-1:0] w_clr_addr;
    logic              w_user_we;
    logic              w_wr_en;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [WIDTH-1:0]  w_wr_data;
    logic [WIDTH-1:0]  w_q [DEPTH];
    logic [WIDTH-1:0]  w_rd1;
    logic [WIDTH-1:0]  w_rd2;

    reg_file_clear_ctrl #(
        .DEPTH      (DEPTH)
    ) u_clear_ctrl (
        .i_clk      (CLK),
        .i_rst      (RST),
        .o_busy     (w_busy),
        .o_clr_we   (w_clr_we),
        .o_clr_addr (w_clr_addr)
    );

    // User writes are dropped during clear and on a reset edge.
    assign w_user_we = ~w_busy & ~RST & EN & (WA != '0);

    // Clear and user writes are mutually exclusive, so BUSY picks the source.
    assign w_wr_en   = w_clr_we | w_user_we;
    assign w_wr_addr = w_busy ? w_clr_addr : WA;
    assign w_wr_data = w_busy ? '0 : WD;

    assign w_q[0] = '0;

    generate
        for (genvar i = 1; i < DEPTH; i++) begin : g_entry
            logic [WIDTH-1:0] r_q;

            always_ff @(posedge CLK) begin
                if (w_wr_en && (w_wr_addr == ADDR_W'(i))) begin
                    r_q <= w_wr_data;
                end
            end

            assign w_q[i] = r_q;
        end
    endgenerate

    always_comb begin
        w_rd1 = w_q[ADR1];
        w_rd2 = w_q[ADR2];
`ifdef REG_FILE_BYPASS_EN
        // WA != 0 is part of the condition, so entry 0 is never bypassed.
        if (~w_busy && EN && (WA != '0)) begin
            if (ADR1 == WA) w_rd1 = WD;
            if (ADR2 == WA) w_rd2 = WD;
        end
`endif
        if (w_busy) begin
            w_rd1 = '0;
            w_rd2 = '0;
        end
    end

    assign RS1  = w_rd1;
    assign RS2  = w_rd2;
    assign BUSY = w_busy;

endmodule : reg_file
`default_nettype wire

// File: tb/tb_reg_file.sv
`default_nettype none
// ============================================================================
// Module   : tb_reg_file
// Purpose  : Self-checking bench for reg_file against an array-based model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_reg_file;

    logic        clk;
    logic        rst;
    logic        en;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  adr1;
    logic [4:0]  adr2;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic        busy;

    int total;
    int bad;

    logic [31:0] model_mem [32];

    reg_file u_dut (
        .CLK  (clk),
        .RST  (rst),
        .EN   (en),
        .WA   (wa),
        .WD   (wd),
        .ADR1 (adr1),
        .ADR2 (adr2),
        .RS1  (rs1),
        .RS2  (rs2),
        .BUSY (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef REG_FILE_BYPASS_EN
    localparam bit c_bypass = 1'b1;
`else
    localparam bit c_bypass = 1'b0;
`endif

    // Expected READY-state read: x0 is zero, a matching accepted write is
    // visible only with bypass, otherwise the stored value.
    function automatic logic [31:0] exp_rd(input logic [4:0] a, input logic e,
                                           input logic [4:0] w, input logic [31:0] d);
        if (a == 5'd0) return 32'h0;
        if (c_bypass && e && (w != 5'd0) && (a == w)) return d;
        return model_mem[a];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) model_mem[i] = 32'h0;
    endtask

    task automatic commit_write();
        if (en && (wa != 5'd0)) model_mem[wa] = wd;
    endtask

    // Count edges until BUSY drops, bounded.
    task automatic wait_ready(output int n);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            tick();
            n++;
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        en  = 1'b0;
        tick();
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        int n;
        rst = 1'b1; en = 1'b0; wa = '0; wd = '0; adr1 = 5'd7; adr2 = 5'd19;
        repeat (3) tick();
        rst = 1'b0;
        model_clear();
        total++;
        if (busy !== 1'b1 || rs1 !== 32'h0 || rs2 !== 32'h0) begin
            $display("FAIL reset_state: busy=%b rs1=%h rs2=%h required busy=1 rs=0", busy, rs1, rs2);
            bad++;
        end
        wait_ready(n);
        total++;
        if (n !== 31) begin
            $display("FAIL clear_latency: edges=%0d required 31", n);
            bad++;
        end
    endtask

    task automatic test_clear_readback();
        for (int a = 0; a < 32; a++) begin
            adr1 = 5'(a);
            adr2 = 5'(31 - a);
            #1;
            total++;
            if (rs1 !== 32'h0 || rs2 !== 32'h0) begin
                $display("FAIL clear_readback a=%0d: rs1=%h rs2=%h required 0", a, rs1, rs2);
                bad++;
            end
        end
    endtask

    task automatic test_write_read();
        en = 1'b1; wa = 5'd5; wd = 32'hdeadbeef;
        commit_write(); tick();
        wa = 5'd31; wd = 32'hfeedfeed;
        commit_write(); tick();
        en = 1'b0; adr1 = 5'd5; adr2 = 5'd31;
        #1;
        total++;
        if (rs1 !== 32'hdeadbeef || rs2 !== 32'hfeedfeed) begin
            $display("FAIL write_read: rs1=%h rs2=%h required deadbeef feedfeed", rs1, rs2);
            bad++;
        end
    endtask

    task automatic test_x0();
        en = 1'b1; wa = 5'd0; wd = 32'haaaadddd;
        commit_write(); tick();
        en = 1'b0; adr1 = 5'd0; adr2 = 5'd5;
        #1;
        total++;
        if (rs1 !== 32'h0 || rs2 !== model_mem[5]) begin
            $display("FAIL x0_protect: rs1=%h rs2=%h required 0 %h", rs1, rs2, model_mem[5]);
            bad++;
        end
    endtask

    task automatic test_write_during_clear();
        int n;
        pulse_reset();
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            en = 1'b1; wa = 5'd3; wd = 32'hdadadada; adr1 = 5'd3; adr2 = 5'd3;
            #1;
            total++;
            if (rs1 !== 32'h0 || rs2 !== 32'h0) begin
                $display("FAIL clear_forced_zero: rs1=%h rs2=%h required 0", rs1, rs2);
                bad++;
            end
            tick();
            n++;
        end
        en = 1'b0;
        total++;
        if (n !== 31) begin
            $display("FAIL clear_latency_2: edges=%0d required 31", n);
            bad++;
        end
        adr1 = 5'd3; adr2 = 5'd5;
        #1;
        total++;
        if (rs1 !== 32'h0 || rs2 !== 32'h0) begin
            $display("FAIL write_during_clear: x3=%h x5=%h required 0 0", rs1, rs2);
            bad++;
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [31:0] v;
        pulse_reset();
        repeat (10) tick();
        // Held reset: stays busy, restart still costs 31 edges.
        rst = 1'b1;
        repeat (4) tick();
        total++;
        if (busy !== 1'b1) begin
            $display("FAIL reset_held_busy: busy=%b required 1", busy);
            bad++;
        end
        rst = 1'b0;
        wait_ready(n);
        total++;
        if (n !== 31) begin
            $display("FAIL reset_mid_latency: edges=%0d required 31", n);
            bad++;
        end
        v = $urandom;
        en = 1'b1; wa = 5'd7; wd = v;
        commit_write(); tick();
        en = 1'b0; adr1 = 5'd7;
        #1;
        total++;
        if (rs1 !== v) begin
            $display("FAIL x7_write: rs1=%h required %h", rs1, v);
            bad++;
        end
        // Reset edge with a write pending must not store it.
        rst = 1'b1; en = 1'b1; wa = 5'd8; wd = 32'hcafef00d;
        tick();
        rst = 1'b0; en = 1'b0;
        model_clear();
        wait_ready(n);
        adr1 = 5'd7; adr2 = 5'd8;
        #1;
        total++;
        if (rs1 !== 32'h0 || rs2 !== 32'h0 || n !== 31) begin
            $display("FAIL reset_clears_x7: x7=%h x8=%h edges=%0d required 0 0 31", rs1, rs2, n);
            bad++;
        end
    endtask

    task automatic test_same_cycle();
        logic [31:0] e;
        en = 1'b1; wa = 5'd9; wd = 32'h1;
        commit_write(); tick();
        wd = 32'h12345678; adr1 = 5'd9; adr2 = 5'd9;
        #1;
        e = c_bypass ? 32'h12345678 : 32'h1;
        total++;
        if (rs1 !== e || rs2 !== e) begin
            $display("FAIL same_cycle: rs1=%h rs2=%h required %h", rs1, rs2, e);
            bad++;
        end
        commit_write(); tick();
        en = 1'b0;
        #1;
        total++;
        if (rs1 !== 32'h12345678) begin
            $display("FAIL same_cycle_next: rs1=%h required 12345678", rs1);
            bad++;
        end
    endtask

    task automatic test_random();
        logic [31:0] e1;
        logic [31:0] e2;
        for (int i = 0; i < 400; i++) begin
            en   = 1'($urandom_range(0, 1));
            wa   = 5'($urandom_range(0, 31));
            wd   = $urandom;
            adr1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            adr2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
            #1;
            e1 = exp_rd(adr1, en, wa, wd);
            e2 = exp_rd(adr2, en, wa, wd);
            total++;
            if (rs1 !== e1 || rs2 !== e2 || busy !== 1'b0) begin
                $display("FAIL random i=%0d a1=%0d a2=%0d wa=%0d en=%b: rs1=%h rs2=%h busy=%b required %h %h 0",
                         i, adr1, adr2, wa, en, rs1, rs2, busy, e1, e2);
                bad++;
            end
            commit_write();
            tick();
        end
        en = 1'b0;
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_clear_readback();
        test_write_read();
        test_x0();
        test_random();
        test_write_during_clear();
        test_reset_mid();
        test_same_cycle();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_reg_file
`default_nettype wire

// File: doc/reg_file.md
# reg_file

Two-read, one-write register file that sits directly downstream of the 32-bit 4:1 write-back mux. The mux output drives `WD` and its select picks the write-back source. After reset, an internal clear sequencer zeroes every register before accepting writes, so the core never reads X state. Reads are combinational. Register 0 is hard-wired to zero.

## Interface
Parameters:
- `WIDTH`, 32: data width of each register.
- `DEPTH`, 32: number of registers. Power of two, ≥ 4. Address width is `$clog2(DEPTH)`.

Ports:
- `CLK`  input  1  clock; all state updates on rising edge.
- `RST`  input  1  reset; synchronous, active-high.
- `EN`  input  1  write enable.
- `WA`  input  $clog2(DEPTH)  write address.
- `WD`  input  WIDTH  write data (from the write-back mux `DOUT`).
- `ADR1`  input  $clog2(DEPTH)  read address, port 1.
- `ADR2`  input  $clog2(DEPTH)  read address, port 2.
- `RS1`  output  WIDTH  read data, port 1.
- `RS2`  output  WIDTH  read data, port 2.
- `BUSY`  output  1  high while the clear sequence runs.

## Operation
- FSM states: CLEAR and READY.
- A rising edge with `RST`=1 moves the FSM to CLEAR and loads the clear counter `CNT` with 1. Register contents are not touched on that edge.
- In CLEAR, each rising edge with `RST`=0 writes 0 to entry `CNT` and increments `CNT`.
  - The edge that clears entry `DEPTH-1` moves the FSM to READY.
  - The counter never wraps past `DEPTH-1`.
- In CLEAR:
  - `BUSY`=1.
  - `RS1` and `RS2` are forced to 0.
  - `EN` is ignored, and the pending write is dropped, not queued.
- In READY:
  - `BUSY`=0.
  - A rising edge with `EN`=1 and `WA`≠0 writes `WD` to entry `WA`.
  - Writes with `WA`=0 are discarded.
- Reads in READY:
  - `RS1` = mem[`ADR1`] and `RS2` = mem[`ADR2`], combinationally.
  - Address 0 always returns 0.
- Both read ports may address the same entry, and may address `WA`, in the same cycle.
- `RST` asserted mid-clear restarts the sequence at `CNT`=1.
- `RST` held high keeps the FSM in CLEAR with `CNT`=1.
- Entry 0 has no storage. Synthesis must not infer a flop for it.

## Timing
- Output values after any reset edge: `BUSY`=1, `RS1`=0, `RS2`=0.
- Clear latency: `BUSY` falls after exactly `DEPTH-1` rising edges with `RST`=0, i.e. 31 edges for the default.
- Write-to-read latency: 1 cycle. A value written at edge N is visible on `RS1`/`RS2` after edge N.
- Same-cycle read of `WA` while `EN`=1 returns the old contents, unless `REG_FILE_BYPASS_EN` is defined.
- Read path is purely combinational from `ADR1`/`ADR2`, FSM state and storage. There is no registered output.

## Configuration
- `REG_FILE_BYPASS_EN` defined:
  - In READY, when `EN`=1, `WA`≠0 and `ADRx`==`WA`, port x returns `WD` combinationally in the same cycle (write-through).
  - Address 0 is never bypassed.
  - Bypass is inactive during CLEAR.
- Not defined: no bypass path; same-cycle reads return pre-write contents.

## Structure
- Package `reg_file_pkg` holds:
  - default constants `REG_WIDTH`=32 and `REG_DEPTH`=32;
  - the state enum typedef `rf_state_t` {CLEAR, READY}.
- Sub-module `reg_file_clear_ctrl` contains the FSM and the `CNT` counter.
  - Outputs: `BUSY`, the clear-write strobe and the clear address.
  - The top level muxes the clear write against the user write into the storage array.

## Test plan
- Reset, clear and read-back:
  - Pulse `RST` for 1 cycle → `BUSY`=1 for 31 cycles, then 0.
  - Reading every address after `BUSY` falls → all return 32'h0.
- Write then read:
  - After clear, write 32'hdeadbeef to x5 and 32'hfeedfeed to x31.
  - Next cycle with `ADR1`=5 and `ADR2`=31 → `RS1`=32'hdeadbeef, `RS2`=32'hfeedfeed.
- x0 protection: write 32'haaaadddd to x0, then read with `ADR1`=0 → `RS1`=0.
- Writes during clear: assert `EN` with `WA`=3 and `WD`=32'hdadadada while `BUSY`=1 → after `BUSY` falls, x3 reads 0.
- Reset mid-clear and mid-operation:
  - Re-assert `RST` at clear cycle 10 → `BUSY` stays high for 31 further cycles.
  - Then write x7, pulse `RST`, wait for `BUSY` to fall → x7 reads 0.
- Same-cycle read/write: `EN`=1, `WA`=9, `WD`=32'h12345678 and `ADR1`=9 in the same cycle, where x9 previously held 32'h1.
  - Without bypass → `RS1`=32'h1 in that cycle, 32'h12345678 next cycle.
  - With `REG_FILE_BYPASS_EN` → `RS1`=32'h12345678 in that cycle.
